// File: rtl/capture_self_timer.sv
// Five-bit seconds countdown for the capture path; o_tick/o_done/o_value are registered and change on the edge after the event.
// No backpressure: i_start is ignored while busy and i_abort always wins; nothing stalls upstream.
module capture_self_timer #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [4:0] i_load_val,
    input  logic       i_pause,
    input  logic       i_abort,
    output logic [4:0] o_value,
    output logic       o_busy,
    output logic       o_tick,
    output logic       o_done
);

    localparam int              PW         = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]   PRESC_TERM = PW'(TICKS_PER_SEC - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [4:0]      value_q, value_d;
    logic            tick_q, tick_d;
    logic            done_q, done_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            value_q <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            value_q <= value_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        value_d = value_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_abort) begin
                    value_d = '0;
                end else if (i_start) begin
                    value_d = i_load_val;
                    presc_d = '0;
                    // A zero load completes immediately without ever running.
                    if (i_load_val != 5'd0) begin
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (i_abort) begin
                    state_d = IDLE;
                    value_d = '0;
                    presc_d = '0;
                end else if (presc_q == PRESC_TERM) begin
                    // Terminal count outranks pause; value is nonzero in RUN so no wrap.
                    presc_d = '0;
                    value_d = value_q - 5'd1;
                    tick_d  = 1'b1;
                    if (value_q == 5'd1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (!i_pause) begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_value = value_q;
    assign o_busy  = (state_q == RUN);
    assign o_tick  = tick_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_capture_self_timer.sv
// Scoreboard bench for capture_self_timer with a one-second step of four clocks.
module tb_capture_self_timer;

    localparam int TPS = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] load_val;
    logic       pause;
    logic       abort;
    logic [4:0] value;
    logic       busy;
    logic       tick;
    logic       done;

    capture_self_timer #(.TICKS_PER_SEC(TPS)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_load_val (load_val),
        .i_pause    (pause),
        .i_abort    (abort),
        .o_value    (value),
        .o_busy     (busy),
        .o_tick     (tick),
        .o_done     (done)
    );

    typedef struct {
        int         cyc;
        logic [4:0] val;
        logic       tick;
        logic       done;
    } ev_t;

    ev_t exp_q[$];
    int  cyc;
    int  n_chk;
    int  n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk = n_chk + 1;
        if (got !== want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Every pulse the DUT emits must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (tick || done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("event_cycle", 32'(cyc), 32'(e.cyc));
                check("event_value", 32'(value), 32'(e.val));
                check("event_tick", 32'(tick), 32'(e.tick));
                check("event_done", 32'(done), 32'(e.done));
                check("event_busy", 32'(busy), 32'(!e.done));
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drives a one-cycle start; when want_ev is set, queues the expected pulses
    // (all shifted by delay cycles) before the accepting edge.
    task automatic do_start(input logic [4:0] n, input bit want_ev, input int delay, output int e0);
        ev_t e;
        @(negedge clk);
        start    = 1'b1;
        load_val = n;
        e0       = cyc + 1;
        if (want_ev) begin
            if (n == 5'd0) begin
                e.cyc = e0; e.val = 5'd0; e.tick = 1'b0; e.done = 1'b1;
                exp_q.push_back(e);
            end else begin
                for (int k = 1; k <= int'(n); k++) begin
                    e.cyc  = e0 + k * TPS + delay;
                    e.val  = 5'(int'(n) - k);
                    e.tick = 1'b1;
                    e.done = (k == int'(n));
                    exp_q.push_back(e);
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int e0;
        int e1;
        int dummy;
        cyc      = 0;
        n_chk    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        load_val = 5'd0;
        pause    = 1'b0;
        abort    = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_value", 32'(value), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic countdown from 3
        do_start(5'd3, 1'b1, 0, e0);
        check("basic_load_value", 32'(value), 3);
        check("basic_load_busy", 32'(busy), 1);
        wait_cyc(e0 + 3);
        check("basic_hold_before_step", 32'(value), 3);
        wait_cyc(e0 + 16);
        check("basic_drain", 32'(exp_q.size()), 0);
        check("basic_idle", 32'(busy), 0);

        // Pause for five edges starting at E0+2
        do_start(5'd2, 1'b1, 5, e0);
        wait_cyc(e0 + 1);
        pause = 1'b1;
        wait_cyc(e0 + 6);
        pause = 1'b0;
        check("pause_value_held", 32'(value), 2);
        wait_cyc(e0 + 16);
        check("pause_drain", 32'(exp_q.size()), 0);

        // Abort on the terminal prescaler count
        do_start(5'd1, 1'b0, 0, e0);
        wait_cyc(e0 + 3);
        check("abort_pre_value", 32'(value), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_value", 32'(value), 0);
        check("abort_busy", 32'(busy), 0);
        repeat (6) @(negedge clk);

        // Abort together with start in IDLE
        start    = 1'b1;
        load_val = 5'd9;
        abort    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", 32'(busy), 0);
        check("abort_start_value", 32'(value), 0);
        repeat (6) @(negedge clk);
        check("abort_start_busy_later", 32'(busy), 0);
        check("abort_drain", 32'(exp_q.size()), 0);

        // Zero load
        do_start(5'd0, 1'b1, 0, e0);
        check("zero_busy", 32'(busy), 0);
        repeat (6) @(negedge clk);
        check("zero_busy_later", 32'(busy), 0);
        check("zero_drain", 32'(exp_q.size()), 0);

        // Maximum load, ignored restart, then back-to-back start on done
        do_start(5'd31, 1'b1, 0, e0);
        wait_cyc(e0 + 8);
        do_start(5'd5, 1'b0, 0, dummy);
        check("max_ignore_value", 32'(value), 29);
        wait_cyc(e0 + 123);
        do_start(5'd2, 1'b1, 0, e1);
        check("b2b_accept_busy", 32'(busy), 1);
        check("b2b_accept_value", 32'(value), 2);
        check("b2b_e0", 32'(e1), 32'(e0 + 125));
        wait_cyc(e1 + 12);
        check("max_b2b_drain", 32'(exp_q.size()), 0);

        // Asynchronous reset mid-run
        do_start(5'd7, 1'b0, 0, e0);
        wait_cyc(e0 + 2);
        check("midrun_value", 32'(value), 7);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_value", 32'(value), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_tick", 32'(tick), 0);
        check("async_rst_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_value", 32'(value), 0);
        check("post_rst_busy", 32'(busy), 0);
        check("final_drain", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_self_timer.md
# capture_self_timer

Five-bit seconds countdown for the camera capture path: loaded with a start value (0-31), it decrements once per second and pulses a done strobe on reaching zero. Its `o_value` drives the two-digit seven-segment decoder directly, so the display shows the remaining seconds. Its `o_done` triggers the frame capture. Pause and abort are supported so a user key can freeze or cancel the countdown.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: i_clk cycles per one-second step. Must be >= 2. The prescaler width is $clog2(TICKS_PER_SEC).
- `i_clk`, input, 1: system clock. All state updates on the rising edge.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_start`, input, 1: single-cycle request to begin a countdown from `i_load_val`.
- `i_load_val`, input, 5: start value in seconds, 0-31. Sampled only on an accepted `i_start`.
- `i_pause`, input, 1: level signal. While high in RUN, the prescaler and value are frozen.
- `i_abort`, input, 1: single-cycle cancel.
- `o_value`, output, 5: remaining seconds. Feeds the seven-segment decoder.
- `o_busy`, output, 1: high while in RUN.
- `o_tick`, output, 1: one-cycle pulse on every decrement, including the final one. Used for the beeper.
- `o_done`, output, 1: one-cycle pulse when the countdown completes normally.

## Operation
- States:
  - IDLE: `o_busy`=0, `o_value` holds its last value.
  - RUN: `o_busy`=1.
- Reset (async assert, any state): state=IDLE, prescaler=0, `o_value`=0, `o_busy`=0, `o_tick`=0, `o_done`=0.
- IDLE, `i_start`=1, `i_load_val`!=0:
  - `o_value`<=`i_load_val`, prescaler<=0, go to RUN.
- IDLE, `i_start`=1, `i_load_val`==0:
  - `o_value`<=0, `o_done` pulses for one cycle, stay in IDLE.
  - `o_tick` does not pulse.
- RUN, no abort, `i_pause`=0: prescaler increments each cycle.
  - At prescaler==TICKS_PER_SEC-1: prescaler wraps to 0, `o_value` decrements, `o_tick` pulses.
  - If the decrement takes `o_value` to 0: `o_done` pulses in the same cycle as that `o_tick`, and state returns to IDLE.
- RUN, `i_pause`=1: prescaler and `o_value` hold, no pulses. Resuming continues from the held prescaler count; the count is not restarted.
- RUN, `i_abort`=1: state goes to IDLE, `o_value`<=0, prescaler<=0, no `o_done`, no `o_tick`.
- `i_abort` in IDLE: `o_value`<=0. No other effect.
- Priority: abort > terminal tick > pause.
  - Abort on the same cycle as a terminal prescaler count suppresses the decrement, `o_tick` and `o_done`.
  - Abort with start in IDLE: abort wins and the start is dropped.
- `i_start` during RUN is ignored. No restart, and `i_load_val` is not sampled.
- Arithmetic:
  - `o_value` only decrements from a nonzero value, so it never wraps below 0.
  - The prescaler compare is unsigned, against TICKS_PER_SEC-1.
- `o_tick` and `o_done` are registered outputs, never combinational from the inputs.

## Timing
- Edge E0 samples an accepted `i_start` (nonzero load N). After E0: `o_value`=N, `o_busy`=1, prescaler=0.
- With no pause, the k-th decrement occurs at edge E0 + k*TICKS_PER_SEC. `o_tick` is high for the cycle after that edge.
- Completion at edge E0 + N*TICKS_PER_SEC. After that edge: `o_value`=0, `o_busy`=0, `o_tick`=1, `o_done`=1, all for one cycle.
- Each paused cycle delays all remaining edges by exactly one cycle.
- Zero-load start: `o_done` is high for the one cycle after E0.
- A new `i_start` is accepted on the first cycle `o_busy`=0, including the cycle in which `o_done` is high.
- Reset mid-RUN: outputs go to reset values immediately (asynchronous). After release, the block stays in IDLE until a new `i_start`.

## Test plan
All scenarios run with TICKS_PER_SEC=4.
- Reset values: assert `i_rst_n`=0 mid-RUN with `o_value`=7 → all outputs 0 without waiting for a clock edge. After release the block is IDLE and `o_value` stays 0 with no start.
- Basic countdown: start with load 3 at E0 → `o_value` reads 3,2,1,0 with changes at E0+4, E0+8, E0+12. `o_tick` pulses 3 times. `o_done` pulses once after E0+12, and `o_busy` falls at the same edge.
- Pause: load 2, hold `i_pause` high for 5 cycles starting at E0+2 → `o_done` moves to E0+13. No pulses occur while paused.
- Abort priority: load 1, assert `i_abort` exactly at E0+3 (terminal prescaler count) → `o_value`=0, IDLE, no `o_tick`, no `o_done`. Separately, abort together with start in IDLE → no RUN entry.
- Zero and maximum load: load 0 → one `o_done`, no `o_tick`, `o_busy` stays 0. Load 31 → `o_done` at E0+124 after 31 ticks. `i_start` with load 5 at E0+10 is ignored, so `o_value` is unaffected.
- Back-to-back: an `i_start` (load 2) on the cycle `o_done` is high → accepted. The second countdown completes 8 cycles later.
